// File: rtl/hub75_pkg.sv
// rtl/hub75_pkg.sv - shared types and default sizes for the HUB75 receiver
package hub75_pkg;

  localparam int DEF_WIDTH      = 64;
  localparam int DEF_ADDR_BITS  = 5;
  localparam int DEF_PLANE_BITS = 3;

  // One colour lane, packed as {B,G,R}
  typedef logic [2:0] rgb_t;

  // Both half-panel lanes captured by a single shift clock
  typedef struct packed {
    rgb_t rgb1;
    rgb_t rgb0;
  } pix_pair_t;

endpackage

// File: rtl/hub75_line_buffer.sv
// rtl/hub75_line_buffer.sv - two-bank line store with capture/drain ownership tracking
module hub75_line_buffer
  import hub75_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AW    = $clog2(DEF_WIDTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  pix_pair_t     wdata_i,
  input  logic [AW-1:0] raddr_i,
  output pix_pair_t     rdata_o,
  input  logic          swap_i,
  input  logic          free_i,
  output logic          drain_free_o
);

  pix_pair_t mem_q [2*WIDTH];
  pix_pair_t rdata_q;
  logic      cap_bank_q;
  logic      busy_q;
  logic      rbank;

  // While swapping, the bank about to become the drain bank is still the capture bank
  assign rbank        = swap_i ? cap_bank_q : ~cap_bank_q;
  // A bank whose last pixel is being accepted this cycle can be reused immediately
  assign drain_free_o = ~busy_q | free_i;
  assign rdata_o      = rdata_q;

  // Capture writes always land in the current capture bank
  always_ff @(posedge clk) begin
    if (we_i) mem_q[{cap_bank_q, waddr_i}] <= wdata_i;
  end

  // Synchronous read of the drain bank
  always_ff @(posedge clk) begin
    if (reset) rdata_q <= '0;
    else       rdata_q <= mem_q[{rbank, raddr_i}];
  end

  // Bank ownership: swap hands the captured line to the drain, free releases it
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_bank_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      if (swap_i) begin
        cap_bank_q <= ~cap_bank_q;
        busy_q     <= 1'b1;
      end else if (free_i) begin
        busy_q     <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/hub75_rx.sv
// rtl/hub75_rx.sv - HUB75 bus receiver producing a tagged pixel stream per latched line
module hub75_rx
  import hub75_pkg::*;
#(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int ADDR_BITS      = DEF_ADDR_BITS,
  parameter int PLANE_BITS     = DEF_PLANE_BITS,
  parameter bit SAMPLE_FALLING = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  hub_sclk,
  input  logic                  hub_latch,
  input  logic                  hub_blank,
  input  logic [ADDR_BITS-1:0]  hub_addr,
  input  logic [2:0]            hub_rgb0,
  input  logic [2:0]            hub_rgb1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [6:0]            out_x,
  output logic [ADDR_BITS-1:0]  out_row,
  output logic [PLANE_BITS-1:0] out_plane,
  output logic [2:0]            out_rgb0,
  output logic [2:0]            out_rgb1,
  output logic                  out_last,
  output logic [7:0]            line_len,
  output logic                  blank_sync,
  output logic                  overrun,
  output logic                  too_long
);

  localparam int AW = $clog2(WIDTH);
  localparam int CW = AW + 1;

  typedef enum logic {ST_IDLE, ST_SEND} state_e;

  logic [2:0]            sclk_q, latch_q;
  logic [1:0]            blank_q;
  logic [ADDR_BITS-1:0]  addr_m_q, addr_s_q;
  pix_pair_t             pix_m_q, pix_s_q;

  logic [CW-1:0]         col_q, drain_len_q;
  logic                  commit_pend_q, too_long_q, overrun_q;
  logic [PLANE_BITS-1:0] plane_q, drain_plane_q;
  logic [ADDR_BITS-1:0]  prev_row_q, drain_row_q;
  logic [7:0]            line_len_q;

  state_e                state_q, state_d;
  logic [AW-1:0]         x_q, x_d, rd_addr;

  logic                  sample_evt, latch_evt, we, commit, last_w, free_w, drain_free;
  pix_pair_t             rdata;

  assign sample_evt = SAMPLE_FALLING ? (~sclk_q[1] & sclk_q[2]) : (sclk_q[1] & ~sclk_q[2]);
  assign latch_evt  = latch_q[1] & ~latch_q[2];
  // The commit cycle owns the column counter, so a sample there is not stored
  assign we         = sample_evt & ~commit_pend_q & (col_q != CW'(WIDTH));
  assign commit     = commit_pend_q & (col_q != '0) & drain_free;
  assign last_w     = (CW'(x_q) + CW'(1)) == drain_len_q;
  assign free_w     = (state_q == ST_SEND) & out_ready & last_w;

  // Two-stage synchronizers; sclk and latch get a third stage for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_q   <= '0;
      latch_q  <= '0;
      blank_q  <= '0;
      addr_m_q <= '0;
      addr_s_q <= '0;
      pix_m_q  <= '0;
      pix_s_q  <= '0;
    end else begin
      sclk_q   <= {sclk_q[1:0], hub_sclk};
      latch_q  <= {latch_q[1:0], hub_latch};
      blank_q  <= {blank_q[0], hub_blank};
      addr_m_q <= hub_addr;
      addr_s_q <= addr_m_q;
      pix_m_q  <= {hub_rgb1, hub_rgb0};
      pix_s_q  <= pix_m_q;
    end
  end

  // Column capture, plane tracking on latch, and line commit one cycle after the latch edge
  always_ff @(posedge clk) begin
    if (reset) begin
      col_q         <= '0;
      too_long_q    <= 1'b0;
      overrun_q     <= 1'b0;
      commit_pend_q <= 1'b0;
      plane_q       <= '0;
      prev_row_q    <= '0;
      line_len_q    <= '0;
      drain_len_q   <= '0;
      drain_row_q   <= '0;
      drain_plane_q <= '0;
    end else begin
      commit_pend_q <= latch_evt;
      if (commit_pend_q) begin
        col_q <= '0;
      end else if (sample_evt) begin
        if (col_q != CW'(WIDTH)) col_q <= col_q + CW'(1);
        else                     too_long_q <= 1'b1;
      end
      if (latch_evt) begin
        if (addr_s_q == prev_row_q) begin
          if (plane_q != '1) plane_q <= plane_q + PLANE_BITS'(1);
        end else begin
          plane_q    <= '0;
          prev_row_q <= addr_s_q;
        end
      end
      if (commit_pend_q) begin
        if (col_q == '0) begin
          line_len_q <= '0;
        end else if (commit) begin
          line_len_q    <= 8'(col_q);
          drain_len_q   <= col_q;
          drain_row_q   <= prev_row_q;
          drain_plane_q <= plane_q;
        end else begin
          overrun_q <= 1'b1;
        end
      end
    end
  end

  // Drain FSM state and column registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
    end
  end

  // Drain next-state: read address always points at the pixel to show next cycle
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    rd_addr = x_q;
    case (state_q)
      ST_IDLE: begin
        if (commit) begin
          state_d = ST_SEND;
          x_d     = '0;
          rd_addr = '0;
        end
      end
      ST_SEND: begin
        if (out_ready) begin
          if (last_w) begin
            if (commit) begin
              x_d     = '0;
              rd_addr = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            x_d     = x_q + AW'(1);
            rd_addr = x_q + AW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  hub75_line_buffer #(.WIDTH(WIDTH), .AW(AW)) u_buf (
    .clk          (clk),
    .reset        (reset),
    .we_i         (we),
    .waddr_i      (col_q[AW-1:0]),
    .wdata_i      (pix_s_q),
    .raddr_i      (rd_addr),
    .rdata_o      (rdata),
    .swap_i       (commit),
    .free_i       (free_w),
    .drain_free_o (drain_free)
  );

  assign out_valid  = (state_q == ST_SEND);
  assign out_x      = 7'(x_q);
  assign out_row    = drain_row_q;
  assign out_plane  = drain_plane_q;
  assign out_rgb0   = out_valid ? rdata.rgb0 : 3'b000;
  assign out_rgb1   = out_valid ? rdata.rgb1 : 3'b000;
  assign out_last   = out_valid & last_w;
  assign line_len   = line_len_q;
  assign blank_sync = blank_q[1];
  assign overrun    = overrun_q;
  assign too_long   = too_long_q;

endmodule

// File: tb/tb_hub75_rx.sv
// tb/tb_hub75_rx.sv - directed self-checking bench for hub75_rx
module tb_hub75_rx;

  logic       clk;
  logic       reset;
  logic       hub_sclk, hub_latch, hub_blank;
  logic [4:0] hub_addr;
  logic [2:0] hub_rgb0, hub_rgb1;
  logic       out_valid, out_ready, out_last;
  logic [6:0] out_x;
  logic [4:0] out_row;
  logic [2:0] out_plane, out_rgb0, out_rgb1;
  logic [7:0] line_len;
  logic       blank_sync, overrun, too_long;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int x;
    int row;
    int plane;
    int r0;
    int r1;
    int last;
  } beat_t;

  beat_t q[$];

  hub75_rx dut (
    .clk        (clk),
    .reset      (reset),
    .hub_sclk   (hub_sclk),
    .hub_latch  (hub_latch),
    .hub_blank  (hub_blank),
    .hub_addr   (hub_addr),
    .hub_rgb0   (hub_rgb0),
    .hub_rgb1   (hub_rgb1),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_x      (out_x),
    .out_row    (out_row),
    .out_plane  (out_plane),
    .out_rgb0   (out_rgb0),
    .out_rgb1   (out_rgb1),
    .out_last   (out_last),
    .line_len   (line_len),
    .blank_sync (blank_sync),
    .overrun    (overrun),
    .too_long   (too_long)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every accepted beat; ready only changes just after a rising edge
  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      beat_t b;
      b.x     = int'(out_x);
      b.row   = int'(out_row);
      b.plane = int'(out_plane);
      b.r0    = int'(out_rgb0);
      b.r1    = int'(out_rgb1);
      b.last  = int'(out_last);
      q.push_back(b);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic shift_col(input logic [2:0] r0);
    logic [2:0] r1;
    r1 = ~r0;
    hub_rgb0 = r0;
    hub_rgb1 = r1;
    wait_clks(3);
    hub_sclk = 1'b1;
    wait_clks(3);
    hub_sclk = 1'b0;
    wait_clks(3);
  endtask

  task automatic shift_line(input int n, input int seed);
    for (int i = 0; i < n; i++) shift_col(3'(i) ^ 3'(seed));
  endtask

  task automatic do_latch();
    hub_latch = 1'b1;
    wait_clks(3);
    hub_latch = 1'b0;
    wait_clks(3);
  endtask

  task automatic wait_beats(input int n, input int budget);
    int k;
    k = 0;
    while (q.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    wait_clks(10);
  endtask

  task automatic check_line(input string tag, input int n, input int row, input int plane, input int seed);
    logic [2:0] e0, e1;
    check({tag, ".beats"}, q.size(), n);
    for (int i = 0; i < q.size() && i < n; i++) begin
      e0 = 3'(i) ^ 3'(seed);
      e1 = ~e0;
      check($sformatf("%s.x%0d", tag, i), q[i].x, i);
      check($sformatf("%s.row%0d", tag, i), q[i].row, row);
      check($sformatf("%s.plane%0d", tag, i), q[i].plane, plane);
      check($sformatf("%s.rgb0_%0d", tag, i), q[i].r0, 32'(e0));
      check($sformatf("%s.rgb1_%0d", tag, i), q[i].r1, 32'(e1));
      check($sformatf("%s.last%0d", tag, i), q[i].last, (i == n - 1) ? 1 : 0);
    end
  endtask

  task automatic send_line(input int n, input int addr, input int seed);
    hub_addr = 5'(addr);
    shift_line(n, seed);
    do_latch();
  endtask

  int         sn, k;
  logic [2:0] s0, s1;

  initial begin
    reset     = 1'b1;
    hub_sclk  = 1'b0;
    hub_latch = 1'b0;
    hub_blank = 1'b0;
    hub_addr  = '0;
    hub_rgb0  = '0;
    hub_rgb1  = '0;
    out_ready = 1'b1;
    wait_clks(3);

    check("rst.valid", out_valid, 0);
    check("rst.x", out_x, 0);
    check("rst.last", out_last, 0);
    check("rst.rgb0", out_rgb0, 0);
    check("rst.line_len", line_len, 0);
    check("rst.overrun", overrun, 0);
    check("rst.too_long", too_long, 0);
    check("rst.blank", blank_sync, 0);
    reset = 1'b0;
    wait_clks(2);

    hub_blank = 1'b1;
    wait_clks(4);
    check("blank.sync", blank_sync, 1);
    hub_blank = 1'b0;

    // Full line on row 7
    send_line(64, 7, 0);
    wait_beats(64, 300);
    check_line("full", 64, 7, 0, 0);
    check("full.line_len", line_len, 64);
    check("full.too_long", too_long, 0);

    // Plane counting: row 7 continues 1..3, row 8 restarts, then saturates
    for (int p = 1; p <= 3; p++) begin
      q.delete();
      send_line(1, 7, p);
      wait_beats(1, 100);
      check_line($sformatf("plane_r7_%0d", p), 1, 7, p, p);
    end
    q.delete();
    send_line(1, 8, 0);
    wait_beats(1, 100);
    check_line("plane_r8_0", 1, 8, 0, 0);
    for (int p = 1; p <= 8; p++) begin
      q.delete();
      send_line(2, 8, p);
      wait_beats(2, 100);
      check_line($sformatf("plane_sat_%0d", p), 2, 8, (p > 7) ? 7 : p, p);
    end
    check("pre.overrun", overrun, 0);

    // Backpressure mid-line, then a line shifted during the drain, then a dropped line
    q.delete();
    send_line(64, 9, 3);
    k = 0;
    while (q.size() < 20 && k < 300) begin
      @(posedge clk);
      k++;
    end
    check("stall.reach", (q.size() >= 20) ? 1 : 0, 1);
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    sn = q.size();
    s0 = 3'(sn) ^ 3'(3);
    s1 = ~s0;
    repeat (10) @(negedge clk);
    check("stall.valid", out_valid, 1);
    check("stall.x", out_x, sn);
    check("stall.rgb0", out_rgb0, 32'(s0));
    check("stall.rgb1", out_rgb1, 32'(s1));
    check("stall.beats", q.size(), sn);
    @(posedge clk);
    #1 out_ready = 1'b1;
    shift_line(64, 5);
    check_line("lineA", 64, 9, 0, 3);
    q.delete();
    do_latch();
    shift_line(1, 6);
    do_latch();
    wait_beats(64, 300);
    wait_clks(40);
    check_line("lineB", 64, 9, 1, 5);
    check("lineC.overrun", overrun, 1);

    // Overlong line after a clean reset
    @(posedge clk);
    #1 reset = 1'b1;
    wait_clks(3);
    reset = 1'b0;
    check("rst2.overrun", overrun, 0);
    q.delete();
    send_line(70, 10, 7);
    wait_beats(64, 300);
    check_line("long", 64, 10, 0, 7);
    check("long.too_long", too_long, 1);
    check("long.line_len", line_len, 64);

    // Latch with no shift clocks
    q.delete();
    do_latch();
    wait_clks(40);
    check("empty.beats", q.size(), 0);
    check("empty.line_len", line_len, 0);

    // Final sample edge coincident with the latch edge
    q.delete();
    hub_addr = 5'd12;
    shift_line(3, 1);
    s0 = 3'(3) ^ 3'(1);
    s1 = ~s0;
    hub_rgb0 = s0;
    hub_rgb1 = s1;
    wait_clks(3);
    hub_sclk = 1'b1;
    wait_clks(3);
    hub_sclk  = 1'b0;
    hub_latch = 1'b1;
    wait_clks(3);
    hub_latch = 1'b0;
    wait_clks(3);
    wait_beats(4, 200);
    check_line("coinc", 4, 12, 0, 1);
    check("coinc.line_len", line_len, 4);

    // Reset while draining aborts the line; next line starts clean
    q.delete();
    send_line(64, 11, 2);
    k = 0;
    while (q.size() < 5 && k < 300) begin
      @(posedge clk);
      k++;
    end
    check("rstsend.reach", (q.size() >= 5) ? 1 : 0, 1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rstsend.valid", out_valid, 0);
    check("rstsend.x", out_x, 0);
    check("rstsend.too_long", too_long, 0);
    check("rstsend.line_len", line_len, 0);
    wait_clks(1);
    reset = 1'b0;
    wait_clks(2);
    q.delete();
    send_line(4, 11, 4);
    wait_beats(4, 200);
    check_line("after_rst", 4, 11, 0, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hub75_rx.md
Name: hub75_rx

Overview:
- HUB75 panel-side receiver: oversamples the serial HUB75 bus (SCLK, LATCH, BLANK, row address, two RGB lanes) driven by our scan controller.
- Reconstructs each shifted line into a double-buffered line store.
- On LATCH, emits the line as a valid/ready pixel stream tagged with column, row and PWM bit-plane index.
- Used as a loopback checker/sniffer and as the input stage for chained panel emulation.

Parameters:
- WIDTH, 64, maximum columns stored per line (power of 2, at most 128).
- ADDR_BITS, 5, row-address width (HUB75 A..E).
- PLANE_BITS, 3, bit-plane counter width.
- SAMPLE_FALLING, 1: 1 = capture RGB on SCLK falling edge (transmitter changes data on rising); 0 = capture on rising edge.

Ports:
- clk  in  1  system clock; must be at least 4x the SCLK frequency.
- reset  in  1  synchronous, active-high.
- hub_sclk  in  1  HUB75 shift clock (asynchronous).
- hub_latch  in  1  HUB75 latch/strobe (asynchronous).
- hub_blank  in  1  HUB75 output enable/blank (asynchronous).
- hub_addr  in  ADDR_BITS  row address (asynchronous).
- hub_rgb0  in  3  upper-half data {B,G,R}.
- hub_rgb1  in  3  lower-half data {B,G,R}.
- out_valid  out  1  pixel stream valid.
- out_ready  in  1  downstream accept.
- out_x  out  7  column index.
- out_row  out  ADDR_BITS  latched row address.
- out_plane  out  PLANE_BITS  bit-plane index of this line.
- out_rgb0  out  3  upper pixel.
- out_rgb1  out  3  lower pixel.
- out_last  out  1  final pixel of the line.
- line_len  out  8  column count of the most recently committed line.
- blank_sync  out  1  synchronized hub_blank.
- overrun  out  1  sticky; a latched line was dropped.
- too_long  out  1  sticky; more than WIDTH SCLK edges occurred in one line.

Behaviour:
- Reset: all outputs 0; column counter 0; both banks marked free; plane counter 0; previous-row register 0; sticky flags cleared. Reset mid-line or mid-drain aborts everything with no partial output.
- Synchronization: every hub_* input passes through a 2-FF synchronizer. A third register on sclk and latch provides edge detection.
- Sample event: a synchronized SCLK edge of the selected polarity writes {rgb1,rgb0} (synchronized copies, same stage) into the capture bank at the current column, then increments the column.
- Column overflow: the column saturates at WIDTH; further samples in that line are discarded and too_long is set.
- Latch event: rising edge of synchronized latch.
  - If a sample event and a latch event fall in the same clk, the sample is written first and belongs to the line being latched.
  - Plane counter: if hub_addr (sync) equals the previous latched row, plane increments, saturating at 2^PLANE_BITS-1. Otherwise plane resets to 0 and the previous-row register is updated.
  - Commit when the drain bank is free: banks swap; line_len, row and plane are captured for the drain; the column counter clears.
  - Commit when the drain bank is still busy: the line is dropped, overrun is set, and the column counter still clears.
  - A latch with column 0 updates row/plane, sets line_len = 0 and emits nothing.
- Drain FSM states:
  - IDLE: on commit of a line with len > 0, go to SEND. out_valid rises exactly 1 clk after the commit cycle; the commit cycle is the clk after latch-edge detection.
  - SEND: presents x = 0..len-1 from the drain bank (synchronous-read RAM with 1-cycle prefetch). All out_* are held stable while out_valid && !out_ready. Advances on out_valid && out_ready. out_last = 1 when x = len-1; its handshake returns to IDLE and frees the bank.
  - Back-to-back: a new commit may occur in the same clk the last pixel is accepted, so the bank is treated as free that clk.
- Sustained throughput is 1 pixel/clk. The drain must finish within one line time to avoid overrun.
- out_x is zero-extended from log2(WIDTH) bits.

Decomposition:
- Package hub75_pkg: RGB lane typedef (3-bit {B,G,R}), pixel-pair typedef, default WIDTH/ADDR_BITS/PLANE_BITS constants.
- Sub-module hub75_line_buffer: two-bank 6-bit-wide RAM. Provides write port (bank select, address, data), synchronous read port, and bank-swap/free tracking.

Test Plan:
- Shift 64 columns with rgb0 = x[2:0] and rgb1 = ~x[2:0], addr = 7, then latch -> 64 beats, x 0..63, row 7, plane 0, out_last only on x = 63, line_len = 64.
- Four consecutive lines on row 7, then one on row 8 -> planes 0, 1, 2, 3, then 0. Eight latches on the same row -> plane saturates at 7.
- Hold out_ready low 10 clk mid-line -> outputs frozen, no beat lost or duplicated. Then latch a second line before the drain completes, followed by a third -> second line emitted intact; third line dropped and overrun = 1.
- 70 SCLK edges before latch -> 64 beats, too_long = 1, line_len = 64. Latch with no SCLK -> no beats, line_len = 0.
- Sample edge coincident with latch edge (driven to coincide after synchronization) -> that column is included. Assert reset during SEND -> out_valid = 0 next clk; following line emitted from x = 0 with plane 0.
